// File: rtl/chdr_chunker_if.sv
// CHDR line stream: one 64-bit line per beat, tlast marks the final line,
// and a transfer happens on a cycle where tvalid and tready are both high.
interface chdr_chunker_if;
  logic [63:0] tdata;
  logic        tlast;
  logic        tvalid;
  logic        tready;

  // Sender side of the stream
  modport master (
    output tdata,
    output tlast,
    output tvalid,
    input  tready
  );

  // Receiver side of the stream
  modport slave (
    input  tdata,
    input  tlast,
    input  tvalid,
    output tready
  );
endinterface

// File: rtl/chdr_chunker.sv
// chdr_chunker: pads each variable-length CHDR packet out to a fixed frame
// of frame_size 64-bit lines. Packet lines pass straight through with no
// added latency, and the filler lines are generated locally. A packet whose
// header length cannot fit in the frame, or whose body runs past the frame
// end, sets a sticky error flag. After that all input is drained and nothing
// is emitted until the next clear or reset.
module chdr_chunker #(
  parameter logic [63:0] PAD_VALUE = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic           clk,
  input  logic           reset,       // asynchronous, active low
  input  logic           clear,       // synchronous, same effect as reset
  input  logic [15:0]    frame_size,  // frame length in lines
  chdr_chunker_if.slave  chdr_i,
  chdr_chunker_if.master chdr_o,
  output logic           error
);

  typedef enum logic [1:0] {
    ST_HEADER,
    ST_DATA,
    ST_PADDING,
    ST_ERROR
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] line_cnt_q, line_cnt_d;
  logic        error_q, error_d;
  logic [15:0] frame_size_q;
  logic        load_pend_q;

  logic [15:0] fs_eff;
  logic [13:0] pkt_lines;
  logic        too_long;
  logic        at_frame_end;
  logic        in_hs;
  logic        out_hs;

  // An async reset cannot load a live input, so frame_size is captured on the
  // first clock after reset release. Until that capture, the live port value
  // is used so that the first cycle out of reset already sees the new size.
  assign fs_eff = load_pend_q ? frame_size : frame_size_q;

  // Round the header byte length up to whole lines. The result fits in
  // 14 bits with no overflow.
  assign pkt_lines = {1'b0, chdr_i.tdata[31:19]} + {13'd0, |chdr_i.tdata[18:16]};
  assign too_long  = {2'b00, pkt_lines} > fs_eff;

  // The line about to be emitted is the last one of the frame.
  assign at_frame_end = (line_cnt_q == (fs_eff - 16'd1));

  assign in_hs  = chdr_i.tvalid & chdr_i.tready;
  assign out_hs = chdr_o.tvalid & chdr_o.tready;
  assign error  = error_q;

  // Next state, line counter, error flag and all stream outputs, decoded from the current state
  always_comb begin
    state_d       = state_q;
    line_cnt_d    = line_cnt_q;
    error_d       = error_q;
    chdr_o.tdata  = chdr_i.tdata;
    chdr_o.tlast  = 1'b0;
    chdr_o.tvalid = 1'b0;
    chdr_i.tready = 1'b0;

    case (state_q)
      ST_HEADER: begin
        if (too_long) begin
          // Swallow the oversize header and drop into the drain state.
          chdr_i.tready = 1'b1;
          if (chdr_i.tvalid) begin
            error_d = 1'b1;
            state_d = ST_ERROR;
          end
        end else begin
          chdr_o.tvalid = chdr_i.tvalid;
          chdr_i.tready = chdr_o.tready;
          chdr_o.tlast  = (fs_eff == 16'd1);
          if (in_hs) begin
            line_cnt_d = 16'd1;
            if (fs_eff == 16'd1) begin
              state_d = ST_HEADER;
            end else if (chdr_i.tlast) begin
              state_d = ST_PADDING;
            end else begin
              state_d = ST_DATA;
            end
          end
        end
      end

      ST_DATA: begin
        chdr_o.tvalid = chdr_i.tvalid;
        chdr_i.tready = chdr_o.tready;
        chdr_o.tlast  = at_frame_end;
        if (in_hs) begin
          line_cnt_d = line_cnt_q + 16'd1;
          if (at_frame_end) begin
            if (chdr_i.tlast) begin
              state_d = ST_HEADER;
            end else begin
              // The body overran the frame. The frame itself is already
              // closed cleanly, and the rest of the packet is dropped.
              error_d = 1'b1;
              state_d = ST_ERROR;
            end
          end else if (chdr_i.tlast) begin
            state_d = ST_PADDING;
          end
        end
      end

      ST_PADDING: begin
        chdr_o.tdata  = PAD_VALUE;
        chdr_o.tvalid = 1'b1;
        chdr_o.tlast  = at_frame_end;
        if (out_hs) begin
          line_cnt_d = line_cnt_q + 16'd1;
          if (at_frame_end) begin
            state_d = ST_HEADER;
          end
        end
      end

      default: begin
        // ST_ERROR: accept and discard everything until clear or reset.
        chdr_i.tready = 1'b1;
        error_d       = 1'b1;
      end
    endcase
  end

  // State register; clear outranks any handshake on the same edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_HEADER;
      line_cnt_q <= 16'd0;
      error_q    <= 1'b0;
    end else if (clear) begin
      state_q    <= ST_HEADER;
      line_cnt_q <= 16'd0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      line_cnt_q <= line_cnt_d;
      error_q    <= error_d;
    end
  end

  // Frame size capture; mid-run changes on the port are ignored until a clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_size_q <= 16'd0;
      load_pend_q  <= 1'b1;
    end else if (clear || load_pend_q) begin
      frame_size_q <= frame_size;
      load_pend_q  <= 1'b0;
    end
  end

endmodule
